// File: rtl/bus_master_arbiter_pkg.sv
// Shared encodings and widths for the bus master arbiter and its watchdog.
package bus_master_arbiter_pkg;

    localparam int unsigned AddrWidth            = 32;
    localparam int unsigned DataWidth            = 32;
    localparam int unsigned DefaultTimeoutCycles = 256;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StResp   = 2'd2,
        StErr    = 2'd3
    } state_e;

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Requester and system-bus signals of the arbiter; master = arbiter side, slave = environment side.
interface bus_master_arbiter_if;
    import bus_master_arbiter_pkg::*;

    logic                 req0, req1;
    logic                 we0, we1;
    logic [AddrWidth-1:0] addr0, addr1;
    logic [DataWidth-1:0] wdata0, wdata1;
    logic                 done0, done1;
    logic                 err0, err1;
    logic [DataWidth-1:0] rdata;
    logic                 bus_stb;
    logic                 bus_we;
    logic [AddrWidth-1:0] bus_addr;
    logic [DataWidth-1:0] bus_wdata;
    logic [DataWidth-1:0] bus_rdata;
    logic                 bus_ack;

    modport master (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata, bus_ack,
        output done0, done1, err0, err1, rdata, bus_stb, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata, bus_ack,
        input  done0, done1, err0, err1, rdata, bus_stb, bus_we, bus_addr, bus_wdata
    );

endinterface

// File: rtl/bus_watchdog.sv
// Saturating strobe-cycle counter; alarm is high once TIMEOUT_CYCLES-1 cycles have been counted.
module bus_watchdog
    import bus_master_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic alarm
);

    localparam int unsigned        CntW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0]    CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign alarm = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !alarm) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_master_arbiter.sv
// Two-requester round-robin bus arbiter with fully registered strobe/ack sequencing.
// Define BUS_ARBITER_TIMEOUT_EN to add the watchdog abort path that raises err0/err1.
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input logic                  clock,
    input logic                  reset_n,
    bus_master_arbiter_if.master bus
);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;
    logic                 bus_stb_q, bus_stb_d;
    logic                 bus_we_q, bus_we_d;
    logic [AddrWidth-1:0] bus_addr_q, bus_addr_d;
    logic [DataWidth-1:0] bus_wdata_q, bus_wdata_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [1:0]           done_q, done_d;
    logic                 grant;

    // A lone request always wins; under contention the loser of the last round goes next.
    assign grant = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [1:0] err_q, err_d;
    logic       alarm;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q == StIdle),
        .count_en(state_q == StActive),
        .alarm   (alarm)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        bus_stb_d    = 1'b0;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        rdata_d      = rdata_q;
        done_d       = '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        err_d        = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    bus_we_d     = grant ? bus.we1    : bus.we0;
                    bus_addr_d   = grant ? bus.addr1  : bus.addr0;
                    bus_wdata_d  = grant ? bus.wdata1 : bus.wdata0;
                    bus_stb_d    = 1'b1;
                    state_d      = StActive;
                end
            end
            StActive: begin
                // Ack is tested first so it beats a same-cycle alarm.
                if (bus.bus_ack) begin
                    rdata_d         = bus.bus_rdata;
                    done_d[owner_q] = 1'b1;
                    state_d         = StResp;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                else if (alarm) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = StErr;
                end
`endif
                else begin
                    bus_stb_d = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            bus_stb_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            rdata_q      <= '0;
            done_q       <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            bus_stb_q    <= bus_stb_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            err_q        <= err_d;
`endif
        end
    end

    assign bus.bus_stb   = bus_stb_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.done0     = done_q[0];
    assign bus.done1     = done_q[1];
`ifdef BUS_ARBITER_TIMEOUT_EN
    assign bus.err0      = err_q[0];
    assign bus.err1      = err_q[1];
`else
    assign bus.err0      = 1'b0;
    assign bus.err1      = 1'b0;
`endif

endmodule

// File: doc/bus_master_arbiter.md
# bus_master_arbiter

Shares the single CPU bus between two masters, instruction fetch (requester 0) and data access (requester 1), and sequences each transfer. It grants one requester at a time with round-robin priority and drives the bus strobe until acknowledge. A watchdog aborts any transfer that exceeds a cycle budget, and the arbiter reports a bus error to the owning requester. It sits between the CPU core's fetch/memory stages and the system bus, and is the sole consumer of the bus timeout function.

## Interface
- `TIMEOUT_CYCLES`, default 256: strobe cycles without acknowledge before abort; legal range ≥ 2.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `req0`, `req1`  in  1 each  transfer request; held high until `done`/`err` of that requester.
- `we0`, `we1`  in  1 each  1 = write.
- `addr0`, `addr1`  in  32 each  byte address, stable while `req` high.
- `wdata0`, `wdata1`  in  32 each  write data, stable while `req` high.
- `done0`, `done1`  out  1 each  one-cycle completion pulse.
- `err0`, `err1`  out  1 each  one-cycle timeout pulse.
- `rdata`  out  32  read data, shared, valid in the `done` cycle.
- `bus_stb`  out  1  bus strobe.
- `bus_we`  out  1  write enable.
- `bus_addr`  out  32  address.
- `bus_wdata`  out  32  write data.
- `bus_rdata`  in  32  read data, sampled with `bus_ack`.
- `bus_ack`  in  1  slave acknowledge.

## Operation
- States: IDLE, ACTIVE, RESP, ERR.
- IDLE:
  - If any `req` is high, grant one requester.
  - Latch its `we`, `addr` and `wdata` into the bus output registers.
  - Record the grant owner, clear the watchdog, go to ACTIVE.
- Arbitration:
  - Round-robin on `last_grant`.
  - If both requests are high, the requester not granted last wins.
  - If only one request is high, it wins regardless of `last_grant`.
- ACTIVE:
  - `bus_stb`=1.
  - If `bus_ack`: capture `bus_rdata` into `rdata`, go to RESP.
  - Else if watchdog alarm: go to ERR.
  - Else: increment the watchdog.
- RESP: owner's `done`=1 for one cycle, go to IDLE.
- ERR:
  - Owner's `err`=1 for one cycle; `bus_stb`=0.
  - `rdata` keeps its previous value.
  - Go to IDLE.
- A requester dropping `req` mid-transfer is ignored. The transfer runs to `done`/`err` and the pulse is still issued.
- Simultaneous `bus_ack` and alarm in the same cycle: ack wins and the transfer completes normally.
- `bus_ack` outside ACTIVE is ignored.
- Watchdog width is clog2(TIMEOUT_CYCLES). Alarm fires when the count equals TIMEOUT_CYCLES−1, so `bus_stb` is high for exactly TIMEOUT_CYCLES cycles before ERR. The count never wraps.

## Timing
- Reset values:
  - State = IDLE.
  - `bus_stb`, `bus_we`, `done0/1`, `err0/1` = 0.
  - `bus_addr`, `bus_wdata`, `rdata` = 0.
  - `last_grant` = 1, so requester 0 wins first.
  - Watchdog = 0.
- All outputs are registered; no combinational input-to-output path.
- Request seen in IDLE at cycle t: `bus_stb` high from t+1.
- Ack at cycle n: `done` at n+1, state IDLE at n+2, next `bus_stb` no earlier than n+3.
- Reset asserted mid-transfer: in the next cycle `bus_stb`=0 and no `done`/`err` pulse is issued. The requester must re-request.

## Configuration
- `BUS_ARBITER_TIMEOUT_EN` defined: watchdog present; behaviour as above.
- `BUS_ARBITER_TIMEOUT_EN` undefined:
  - Watchdog and ERR state are removed.
  - `err0/1` are tied to 0.
  - ACTIVE waits indefinitely for `bus_ack`.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package holds:
  - State encoding constants (IDLE=2'd0, ACTIVE=2'd1, RESP=2'd2, ERR=2'd3).
  - Bus width constants (address 32, data 32).
  - Default `TIMEOUT_CYCLES`.
- One sub-module, `bus_watchdog`:
  - Inputs: `clock`, `reset_n`, `clear`, `count_en`.
  - Output: `alarm`.
  - Parameter: `TIMEOUT_CYCLES`.
  - Instantiated only under `BUS_ARBITER_TIMEOUT_EN`.

## Test plan
- Single read:
  - Stimulus: `req0`=1, `addr0`=0x0000_1000, slave acks 3 cycles after `bus_stb` rises with `bus_rdata`=0xDEADBEEF.
  - Response: `done0` pulses once with `rdata`=0xDEADBEEF; `done1`/`err*` stay 0.
- Contention:
  - Stimulus: `req0` and `req1` held high together, slave acks in 1 cycle.
  - Response: grants alternate 0,1,0,1 over 4 transfers, with `bus_addr` matching the owner each time.
- Timeout (macro defined, TIMEOUT_CYCLES=16):
  - Stimulus: write via `req1`, no ack.
  - Response: `bus_stb` high for exactly 16 cycles, then `err1` pulses once; a following request is served normally.
- Ack/alarm collision:
  - Stimulus: ack in the 16th strobe cycle.
  - Response: `done` pulses, `err` stays 0.
- Reset mid-transfer:
  - Stimulus: `reset_n`=0 for 1 cycle during ACTIVE.
  - Response: `bus_stb`=0 next cycle, no `done`/`err`, and requester 0 wins the next contention.
- Macro undefined:
  - Stimulus: no ack for 1000 cycles.
  - Response: `bus_stb` stays high, `err*` stay 0; a late ack produces `done`.
